shared_mem_arb: RTL and testbench

SHARED_MEM_ARB -- requirements
Module: shared_mem_arb

---
 rtl/shared_mem_arb_if.sv | 29 ++
 rtl/shared_mem_arb.sv | 149 ++++++++++++++
 tb/tb_shared_mem_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_arb_if.sv
// Requester-side bus of shared_mem_arb: per-port request/direction/address/data/mask in,
// per-port completion pulse and registered read data out, plus arbiter status.
interface shared_mem_arb_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
) ();
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]          request;
    logic [NUM_PORTS-1:0]          we_re;
    logic [NUM_PORTS*ADDR_W-1:0]   address;
    logic [NUM_PORTS*DATA_W-1:0]   data_in;
    logic [NUM_PORTS*DATA_W/8-1:0] mask;
    logic [NUM_PORTS-1:0]          valid;
    logic [NUM_PORTS*DATA_W-1:0]   data_out;
    logic                          busy;
    logic [GW-1:0]                 grant_id;

    modport master (
        output request, we_re, address, data_in, mask,
        input  valid, data_out, busy, grant_id
    );

    modport slave (
        input  request, we_re, address, data_in, mask,
        output valid, data_out, busy, grant_id
    );
endinterface

// File: rtl/shared_mem_arb.sv
// Round-robin arbiter sharing one byte-maskable memory among NUM_PORTS requesters,
// with a fixed LATENCY-cycle access phase and a one-cycle completion pulse.
//
// state  | meaning
// IDLE   | waiting; grants the first requester at or after ptr
// ACCESS | latched transaction, cnt counts down; memory op on cnt == 0
// RESP   | valid pulse to the granted port, then back to IDLE
module shared_mem_arb #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 1
) (
    input  logic            clk,
    input  logic            rst,
    shared_mem_arb_if.slave bus
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int MW = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;
    logic [GW-1:0]               ptr_q;
    logic [GW-1:0]               grant_q;
    logic [GW-1:0]               pick;
    logic [GW-1:0]               ptr_nxt;
    logic                        found;
    logic                        do_grant;
    logic                        do_commit;
    logic                        lat_we;
    logic [ADDR_W-1:0]           lat_addr;
    logic [DATA_W-1:0]           lat_data;
    logic [MW-1:0]               lat_mask;
    logic [NUM_PORTS*DATA_W-1:0] dout_q;
    logic [NUM_PORTS-1:0]        valid_c;
    int                          sum;
    int                          nxt;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // First requester at or after ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
            if (!found && bus.request[GW'(sum)]) begin
                found = 1'b1;
                pick  = GW'(sum);
            end
        end
        nxt = int'(pick) + 1;
        if (nxt >= NUM_PORTS) nxt = 0;
        ptr_nxt = GW'(nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_grant  = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    do_grant = 1'b1;
                    cnt_d    = CW'(LATENCY - 1);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    do_commit = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction fields are captured only on the grant edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_mask <= '0;
        end else if (do_grant) begin
            ptr_q    <= ptr_nxt;
            grant_q  <= pick;
            lat_we   <= bus.we_re[pick];
            lat_addr <= bus.address[int'(pick)*ADDR_W +: ADDR_W];
            lat_data <= bus.data_in[int'(pick)*DATA_W +: DATA_W];
            lat_mask <= bus.mask[int'(pick)*MW +: MW];
        end
    end

    // Memory is deliberately not reset; reset forces IDLE, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (do_commit && lat_we) begin
            for (int b = 0; b < MW; b++) begin
                if (lat_mask[b]) mem[lat_addr][b*8 +: 8] <= lat_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (do_commit && !lat_we) begin
            dout_q[int'(grant_q)*DATA_W +: DATA_W] <= mem[lat_addr];
        end
    end

    always_comb begin
        valid_c = '0;
        if (state_q == RESP) valid_c[grant_q] = 1'b1;
    end

    assign bus.valid    = valid_c;
    assign bus.data_out = dout_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_shared_mem_arb.sv
// Scoreboard bench for shared_mem_arb: three instances (LATENCY 1, 3, 4) share one clock,
// each with its own reset; directed stimulus pushes expectations, a monitor pops on valid.
module tb_shared_mem_arb;
    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic [2:0]  rst_v;
    logic [1:0]  req_v  [3];
    logic [1:0]  we_v   [3];
    logic [15:0] addr_v [3];
    logic [63:0] din_v  [3];
    logic [7:0]  mask_v [3];
    logic [1:0]  vld_v  [3];
    logic [63:0] dout_v [3];
    logic        busy_v [3];
    logic        gid_v  [3];

    exp_t sbq [3][$];
    exp_t mon_e;
    int   passes = 0;
    int   total  = 0;

    shared_mem_arb_if #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32)) bus0 ();
    shared_mem_arb_if #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32)) bus1 ();
    shared_mem_arb_if #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32)) bus2 ();

    assign bus0.request = req_v[0];
    assign bus0.we_re   = we_v[0];
    assign bus0.address = addr_v[0];
    assign bus0.data_in = din_v[0];
    assign bus0.mask    = mask_v[0];
    assign vld_v[0]     = bus0.valid;
    assign dout_v[0]    = bus0.data_out;
    assign busy_v[0]    = bus0.busy;
    assign gid_v[0]     = bus0.grant_id;

    assign bus1.request = req_v[1];
    assign bus1.we_re   = we_v[1];
    assign bus1.address = addr_v[1];
    assign bus1.data_in = din_v[1];
    assign bus1.mask    = mask_v[1];
    assign vld_v[1]     = bus1.valid;
    assign dout_v[1]    = bus1.data_out;
    assign busy_v[1]    = bus1.busy;
    assign gid_v[1]     = bus1.grant_id;

    assign bus2.request = req_v[2];
    assign bus2.we_re   = we_v[2];
    assign bus2.address = addr_v[2];
    assign bus2.data_in = din_v[2];
    assign bus2.mask    = mask_v[2];
    assign vld_v[2]     = bus2.valid;
    assign dout_v[2]    = bus2.data_out;
    assign busy_v[2]    = bus2.busy;
    assign gid_v[2]     = bus2.grant_id;

    shared_mem_arb #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst_v[0]), .bus(bus0));
    shared_mem_arb #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst_v[1]), .bus(bus1));
    shared_mem_arb #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst_v[2]), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (vld_v[d][p]) begin
                    if (sbq[d].size() == 0) begin
                        total++;
                        $display("FAIL unexpected_valid: dut %0d port %0d pulsed valid, required none", d, p);
                    end else begin
                        mon_e = sbq[d].pop_front();
                        check("sb_port", 64'(p), 64'(mon_e.port));
                        if (mon_e.rd) check("sb_rdata", 64'(dout_v[d][p*32 +: 32]), 64'(mon_e.data));
                    end
                end
            end
        end
    end

    // Called one step after a rising edge with the DUT idle; returns one step after the
    // first IDLE edge following the valid cycle.
    task automatic txn(input int d, input int p, input bit we, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] m,
                       input logic [31:0] rd_exp, input bit drop_early);
        int   lat;
        exp_t e;
        lat = lat_of(d);
        req_v[d][p]            = 1'b1;
        we_v[d][p]             = we;
        addr_v[d][p*8 +: 8]    = a;
        din_v[d][p*32 +: 32]   = wd;
        mask_v[d][p*4 +: 4]    = m;
        e.port = p;
        e.rd   = !we;
        e.data = rd_exp;
        sbq[d].push_back(e);
        check("busy_c0", 64'(busy_v[d]), 64'd0);
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            if (drop_early && c == 1) begin
                req_v[d][p]          = 1'b0;
                addr_v[d][p*8 +: 8]  = a + 8'd1;
                din_v[d][p*32 +: 32] = ~wd;
                we_v[d][p]           = ~we;
            end
            check("busy_active", 64'(busy_v[d]), 64'd1);
            if (c <= lat) check("valid_early", 64'(vld_v[d]), 64'd0);
            else          check("valid_cycle", 64'(vld_v[d]), 64'(2'b01 << p));
        end
        req_v[d][p] = 1'b0;
        @(posedge clk); #1;
        check("busy_after", 64'(busy_v[d]), 64'd0);
        check("valid_after", 64'(vld_v[d]), 64'd0);
    endtask

    initial begin
        logic [1:0] rr_exp;
        exp_t       e;
        rst_v = 3'b000;
        for (int d = 0; d < 3; d++) begin
            req_v[d]  = '0;
            we_v[d]   = '0;
            addr_v[d] = '0;
            din_v[d]  = '0;
            mask_v[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", 64'(vld_v[d]), 64'd0);
            check("rst_busy", 64'(busy_v[d]), 64'd0);
            check("rst_gid", 64'(gid_v[d]), 64'd0);
            check("rst_dout", dout_v[d], 64'd0);
        end
        rst_v = 3'b111;

        // LATENCY 1: single write/read, byte mask merge, zero-mask write.
        txn(0, 0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn(0, 0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        check("rd_dout0", 64'(dout_v[0][31:0]), 64'hDEADBEEF);
        txn(0, 0, 1'b1, 8'h05, 32'h11223344, 4'hF, 32'h0, 1'b0);
        txn(0, 0, 1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        txn(0, 0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        txn(0, 1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn(0, 0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Reset ptr (last grant was port0, so a stale ptr would favour port1), then round-robin.
        rst_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_v[0] = 1'b1;
        req_v[0]  = 2'b11;
        we_v[0]   = 2'b00;
        addr_v[0] = {8'h05, 8'h10};
        for (int k = 0; k < 4; k++) begin
            e.port = k % 2;
            e.rd   = 1'b1;
            e.data = (k % 2 == 0) ? 32'hDEADBEEF : 32'h11BB33DD;
            sbq[0].push_back(e);
        end
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            rr_exp = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check("rr_valid", 64'(vld_v[0]), 64'(rr_exp));
        end
        req_v[0] = 2'b00;
        @(posedge clk); #1;
        check("rr_idle", 64'(busy_v[0]), 64'd0);

        // Dropped request mid-ACCESS with scrambled inputs, then data_out hold across a write.
        txn(0, 1, 1'b0, 8'h05, 32'h0, 4'h0, 32'h11BB33DD, 1'b1);
        check("gid_hold", 64'(gid_v[0]), 64'd1);
        txn(0, 0, 1'b1, 8'h05, 32'h99999999, 4'hF, 32'h0, 1'b0);
        check("dout1_hold_wr", 64'(dout_v[0][63:32]), 64'h11BB33DD);
        txn(0, 0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h99999999, 1'b0);
        check("dout1_hold_rd", 64'(dout_v[0][63:32]), 64'h11BB33DD);

        // LATENCY 4: write/read, zero-mask write leaves word intact.
        txn(2, 0, 1'b1, 8'h20, 32'h01234567, 4'hF, 32'h0, 1'b0);
        txn(2, 1, 1'b0, 8'h20, 32'h0, 4'h0, 32'h01234567, 1'b0);
        txn(2, 1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn(2, 0, 1'b0, 8'h20, 32'h0, 4'h0, 32'h01234567, 1'b0);

        // LATENCY 3: reset during ACCESS aborts a write before its commit edge.
        txn(1, 0, 1'b1, 8'h07, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
        txn(1, 1, 1'b0, 8'h07, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
        req_v[1]          = 2'b10;
        we_v[1]           = 2'b10;
        addr_v[1][15:8]   = 8'h07;
        din_v[1][63:32]   = 32'hCAFEF00D;
        mask_v[1][7:4]    = 4'hF;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy_v[1]), 64'd1);
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        #1;
        check("abort_rst_valid", 64'(vld_v[1]), 64'd0);
        check("abort_rst_busy", 64'(busy_v[1]), 64'd0);
        check("abort_rst_gid", 64'(gid_v[1]), 64'd0);
        check("abort_rst_dout", dout_v[1], 64'd0);
        req_v[1] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_busy", 64'(busy_v[1]), 64'd0);
        check("abort_hold_dout", dout_v[1], 64'd0);
        rst_v[1] = 1'b1;
        @(posedge clk); #1;
        txn(1, 0, 1'b0, 8'h07, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check("sb_drain", 64'(sbq[d].size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
